pipo_load_arb: RTL and testbench

Round-robin arbiter and load sequencer sharing one parallel-in/parallel-out register among NREQ requesters. Each requester presents a WIDTH-bit word and a request. The block grants one requester at a time, loads that requester's word into the shared register, and tags the result with its source. It sits between the requesting datapath units and downstream consumers of the shared register.

---
 rtl/pipo_load_arb.sv | 147 ++++++++++++++
 tb/tb_pipo_load_arb.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipo_load_arb.sv
// Round-robin arbiter that loads one requester word into a shared
// PIPO register and tags it with the source index.
module pipo_load_arb #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned NREQ  = 4,
   parameter int unsigned SRCW  = 2,
   parameter int unsigned GAP   = 1
) (
   input  logic                  clk,
   input  logic                  clear,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] din,
   output logic [NREQ-1:0]       gnt,
   output logic [WIDTH-1:0]      po,
   output logic                  po_valid,
   output logic [SRCW-1:0]       po_src,
   output logic                  busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_GAP  = 2'd2
   } state_t;

   localparam logic [SRCW-1:0] LAST_RST = SRCW'(NREQ - 1);
   localparam logic [3:0]      CNT_INIT = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

   state_t            state;
   state_t            nxt;
   logic [SRCW-1:0]   last;
   logic [SRCW-1:0]   win;
   logic [3:0]        cnt;

   logic              found;
   logic [SRCW-1:0]   pick;
   logic [SRCW-1:0]   idx;

   logic [NREQ-1:0]   gnt_d;
   logic [WIDTH-1:0]  po_d;
   logic              pv_d;
   logic [SRCW-1:0]   src_d;
   logic              busy_d;
   logic [SRCW-1:0]   last_d;
   logic [SRCW-1:0]   win_d;
   logic [3:0]        cnt_d;

   // Round-robin search: start just after the last served requester.
   always_comb begin
      found = 1'b0;
      pick  = last;
      idx   = last;
      for (int k = 1; k <= int'(NREQ); k++) begin
         idx = SRCW'((int'(last) + k) % int'(NREQ));
         if (!found && req[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end
   end

   // State register.
   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         state <= S_IDLE;
      end else begin
         state <= nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      nxt = state;
      unique case (state)
         S_IDLE: begin
            if (found) nxt = S_LOAD;
         end
         S_LOAD: begin
            if (req[win] && (GAP > 0)) nxt = S_GAP;
            else                       nxt = S_IDLE;
         end
         S_GAP: begin
            if (cnt == 4'd0) nxt = S_IDLE;
         end
         default: nxt = S_IDLE;
      endcase
   end

   // Next values of the registered outputs and bookkeeping.
   always_comb begin
      gnt_d  = '0;
      po_d   = po;
      pv_d   = 1'b0;
      src_d  = po_src;
      last_d = last;
      win_d  = win;
      cnt_d  = cnt;
      busy_d = (nxt != S_IDLE);
      unique case (state)
         S_IDLE: begin
            if (found) begin
               gnt_d = NREQ'(1) << pick;
               win_d = pick;
            end
         end
         S_LOAD: begin
            if (req[win]) begin
               po_d   = din[win*WIDTH +: WIDTH];
               src_d  = win;
               pv_d   = 1'b1;
               last_d = win;
               cnt_d  = CNT_INIT;
            end
         end
         S_GAP: begin
            if (cnt != 4'd0) cnt_d = cnt - 4'd1;
         end
         default: begin
            gnt_d = '0;
         end
      endcase
   end

   // Output and bookkeeping registers.
   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         gnt      <= '0;
         po       <= '0;
         po_valid <= 1'b0;
         po_src   <= '0;
         busy     <= 1'b0;
         last     <= LAST_RST;
         win      <= '0;
         cnt      <= 4'd0;
      end else begin
         gnt      <= gnt_d;
         po       <= po_d;
         po_valid <= pv_d;
         po_src   <= src_d;
         busy     <= busy_d;
         last     <= last_d;
         win      <= win_d;
         cnt      <= cnt_d;
      end
   end

endmodule

// File: tb/tb_pipo_load_arb.sv
// Scoreboard bench for pipo_load_arb: directed scenarios followed by
// randomized requesters, checked against a transaction-level model.
module tb_pipo_load_arb;

   localparam int WIDTH = 4;
   localparam int NREQ  = 4;
   localparam int SRCW  = 2;
   localparam int GAP   = 1;

   logic                  clk = 1'b0;
   logic                  clear = 1'b1;
   logic [NREQ-1:0]       req = '0;
   logic [NREQ*WIDTH-1:0] din = '0;
   logic [NREQ-1:0]       gnt;
   logic [WIDTH-1:0]      po;
   logic                  po_valid;
   logic [SRCW-1:0]       po_src;
   logic                  busy;

   pipo_load_arb #(
      .WIDTH(WIDTH), .NREQ(NREQ), .SRCW(SRCW), .GAP(GAP)
   ) dut (
      .clk(clk), .clear(clear), .req(req), .din(din),
      .gnt(gnt), .po(po), .po_valid(po_valid),
      .po_src(po_src), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [WIDTH-1:0] po;
      logic [SRCW-1:0]  src;
   } exp_t;

   exp_t            pq[$];
   logic [NREQ-1:0] gq[$];

   int nchk = 0;
   int npass = 0;

   // model state
   int        cyc = 0;
   int        free_at = 0;
   int        load_win = -1;
   int        load_edge = 0;
   int        last = NREQ - 1;
   bit [NREQ-1:0] served = '0;

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] exp);
      nchk++;
      if (got === exp) npass++;
      else $display("FAIL %s got=%0h exp=%0h", name, got, exp);
   endtask

   function automatic int rr(input logic [NREQ-1:0] r, input int l);
      for (int k = 1; k <= NREQ; k++)
         if (r[(l + k) % NREQ]) return (l + k) % NREQ;
      return -1;
   endfunction

   // Reference model: the block is free from edge free_at on; a grant
   // takes one edge, the load the next, then GAP idle edges.
   initial forever begin
      @(posedge clk);
      if (clear) begin
         last = NREQ - 1;
         load_win = -1;
         free_at = 0;
         cyc = 0;
         pq.delete();
         gq.delete();
      end else begin
         cyc++;
         if (load_win >= 0 && cyc == load_edge) begin
            if (req[load_win]) begin
               pq.push_back(exp_t'{din[load_win*WIDTH +: WIDTH],
                                   SRCW'(load_win)});
               last = load_win;
               served[load_win] = 1'b1;
               free_at = cyc + 1 + GAP;
            end else begin
               free_at = cyc + 1;
            end
            load_win = -1;
         end else if (load_win < 0 && cyc >= free_at && req != 0) begin
            load_win = rr(req, last);
            load_edge = cyc + 1;
            gq.push_back(NREQ'(1) << load_win);
         end
      end
   end

   // Monitor: compare every grant and every po_valid against the queues.
   initial forever begin
      exp_t e;
      logic [NREQ-1:0] g;
      @(negedge clk);
      if (!clear) begin
         if (gnt != 0) begin
            if (gq.size() == 0) begin
               nchk++;
               $display("FAIL gnt_unexpected got=%b exp=none", gnt);
            end else begin
               g = gq.pop_front();
               chk("sb_gnt", 32'(gnt), 32'(g));
            end
         end
         if (po_valid) begin
            if (pq.size() == 0) begin
               nchk++;
               $display("FAIL po_unexpected got=%h/%0d exp=none",
                        po, po_src);
            end else begin
               e = pq.pop_front();
               chk("sb_po", 32'(po), 32'(e.po));
               chk("sb_src", 32'(po_src), 32'(e.src));
            end
         end
      end
   end

   initial begin
      int np;
      logic [WIDTH-1:0] hold;

      // reset state
      repeat (2) @(negedge clk);
      chk("rst_gnt", 32'(gnt), 0);
      chk("rst_po", 32'(po), 0);
      chk("rst_pv", 32'(po_valid), 0);
      chk("rst_src", 32'(po_src), 0);
      chk("rst_busy", 32'(busy), 0);
      clear = 1'b0;

      // first grant
      req = 4'b0001;
      din[3:0] = 4'h9;
      @(negedge clk);
      chk("fg_gnt", 32'(gnt), 32'h1);
      chk("fg_busy", 32'(busy), 1);
      @(negedge clk);
      req = '0;
      chk("fg_po", 32'(po), 32'h9);
      chk("fg_pv", 32'(po_valid), 1);
      chk("fg_src", 32'(po_src), 0);
      chk("fg_gnt0", 32'(gnt), 0);
      chk("fg_busy_gap", 32'(busy), 1);
      @(negedge clk);
      chk("fg_idle", 32'(busy), 0);

      // round-robin fairness from a fresh reset
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      req = 4'b1111;
      din = 16'hDCBA;
      np = 0;
      repeat (15) begin
         @(negedge clk);
         if (po_valid) np++;
      end
      req = '0;
      chk("rr_pulses", 32'(np), 5);
      repeat (2) @(negedge clk);

      // priority rotation
      req = 4'b0010;
      din[7:4] = 4'h6;
      din[3:0] = 4'h3;
      repeat (2) @(negedge clk);
      chk("rot_first", 32'(po_src), 1);
      req = 4'b0011;
      repeat (3) @(negedge clk);
      chk("rot_pv0", 32'(po_valid), 1);
      chk("rot_src0", 32'(po_src), 0);
      repeat (3) @(negedge clk);
      chk("rot_pv1", 32'(po_valid), 1);
      chk("rot_src1", 32'(po_src), 1);
      req = '0;
      @(negedge clk);

      // abandoned load
      hold = po;
      req = 4'b0100;
      din[11:8] = 4'h7;
      @(negedge clk);
      chk("ab_gnt", 32'(gnt), 32'h4);
      req = '0;
      @(negedge clk);
      chk("ab_po", 32'(po), 32'(hold));
      chk("ab_pv", 32'(po_valid), 0);
      chk("ab_busy", 32'(busy), 0);
      chk("ab_gnt0", 32'(gnt), 0);
      @(negedge clk);

      // asynchronous reset during a load
      req = 4'b0010;
      din[7:4] = 4'hE;
      @(negedge clk);
      chk("ar_gnt", 32'(gnt), 32'h2);
      #2 clear = 1'b1;
      #1;
      chk("ar_gnt0", 32'(gnt), 0);
      chk("ar_po0", 32'(po), 0);
      chk("ar_pv0", 32'(po_valid), 0);
      chk("ar_busy0", 32'(busy), 0);
      @(negedge clk);
      clear = 1'b0;
      @(negedge clk);
      chk("ar_regnt", 32'(gnt), 32'h2);
      @(negedge clk);
      chk("ar_po", 32'(po), 32'hE);
      chk("ar_src", 32'(po_src), 1);
      req = '0;
      repeat (3) @(negedge clk);

      // randomized requesters
      served = '0;
      repeat (3000) begin
         @(negedge clk);
         for (int i = 0; i < NREQ; i++) begin
            if (load_win == i) begin
               if ($urandom_range(3) == 0) req[i] = 1'b0;
            end else if (req[i]) begin
               if (served[i]) begin
                  served[i] = 1'b0;
                  if ($urandom_range(1) == 0) req[i] = 1'b0;
               end
            end else if ($urandom_range(2) == 0) begin
               req[i] = 1'b1;
               served[i] = 1'b0;
               din[i*WIDTH +: WIDTH] = WIDTH'($urandom);
            end
         end
      end
      req = '0;
      repeat (10) @(negedge clk);
      chk("end_pq_empty", 32'(pq.size()), 0);
      chk("end_gq_empty", 32'(gq.size()), 0);
      chk("end_idle", 32'(busy), 0);

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule
